uart_rx_fifo: RTL and testbench

- Serial UART receiver: recovers 8N1 frames from `rxd` (LSB first, idle high) and buffers received bytes in a small FIFO.
- Downstream logic drains the FIFO with a read strobe.
- It is the receive-side partner of the team's UART transmitter and sits between the serial pin and the game/control logic.

---
 rtl/uart_rx_fifo.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a first-word-fall-through receive FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames and the parity_err output.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  input  logic                          rd_en,
  output logic [7:0]                    rx_data,
  output logic                          rx_empty,
  output logic                          rx_full,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_err,
`endif
  output logic                          overrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [9:0] H_M1   = 10'(CLKS_PER_BIT / 2 - 1);
  localparam logic [9:0] BIT_M1 = 10'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
  localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

  logic        r_sync1, r_sync2;
  logic [2:0]  r_state;
  logic [9:0]  r_timer;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        r_push;
  logic [7:0]  r_push_data;
  logic        r_frame_err, r_overrun;
  logic [AW:0] r_wptr, r_rptr;
  logic [7:0]  r_mem [FIFO_DEPTH];
`ifdef UART_RX_PARITY_EN
  logic        r_perr, r_push_perr, r_parity_err;
`endif

  logic w_rxs, w_bit_done, w_pop, w_push;
  assign w_rxs      = r_sync2;
  assign w_bit_done = (r_timer == BIT_M1);

  // Receive FSM; the completed byte is handed to the FIFO one edge after the stop sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr      <= 1'b0;
      r_push_perr <= 1'b0;
`endif
    end else begin
      r_sync1     <= rxd;
      r_sync2     <= r_sync1;
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_timer <= '0;
          if (!w_rxs) r_state <= S_START;
        end
        S_START: begin
          if (r_timer == H_M1) begin
            r_timer <= '0;
            r_idx   <= '0;
            r_state <= w_rxs ? S_IDLE : S_DATA;
          end else r_timer <= r_timer + 10'd1;
        end
        S_DATA: begin
          if (w_bit_done) begin
            r_timer        <= '0;
            r_shift[r_idx] <= w_rxs;
            r_idx          <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= S_AFTER_DATA;
          end else r_timer <= r_timer + 10'd1;
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_bit_done) begin
            r_timer <= '0;
            r_perr  <= (^r_shift) ^ w_rxs;
            r_state <= S_STOP;
          end else r_timer <= r_timer + 10'd1;
        end
`endif
        S_STOP: begin
          if (w_bit_done) begin
            r_timer <= '0;
            if (w_rxs) begin
              r_push      <= 1'b1;
              r_push_data <= r_shift;
`ifdef UART_RX_PARITY_EN
              r_push_perr <= r_perr;
`endif
              r_state     <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else r_timer <= r_timer + 10'd1;
        end
        S_BREAK: if (w_rxs) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rx_count = r_wptr - r_rptr;
  assign rx_empty = (r_wptr == r_rptr);
  assign rx_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop    = rd_en && !rx_empty;
  // A full FIFO still takes the byte when the head is being popped in the same cycle.
  assign w_push   = r_push && (!rx_full || w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_overrun    <= r_push && !w_push;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= w_push && r_push_perr;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= r_push_data;
  end

  assign rx_data   = rx_empty ? 8'h00 : r_mem[r_rptr[AW-1:0]];
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_parity_err;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, corner sequences, random frames vs a queue model.
module tb_uart_rx_fifo;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int LAT = 11 + (FB - 1) * CPB;

  logic       clk = 1'b0, rst = 1'b0, rxd = 1'b1, rd_en = 1'b0;
  logic [7:0] rx_data;
  logic       rx_empty, rx_full, frame_err, overrun;
  logic [2:0] rx_count;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  int         n_perr = 0;
`endif

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rd_en(rd_en),
    .rx_data(rx_data), .rx_empty(rx_empty), .rx_full(rx_full), .rx_count(rx_count),
    .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_chk = 0;
  int n_ferr = 0, n_ovr = 0;
  bit both_seen = 1'b0;

  always @(negedge clk) begin
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (frame_err && overrun) both_seen = 1'b1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) n_perr++;
`endif
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input logic par_flip);
    rxd = 1'b0; tick(CPB);
    for (int i = 0; i < 8; i++) begin rxd = d[i]; tick(CPB); end
`ifdef UART_RX_PARITY_EN
    rxd = (^d) ^ par_flip; tick(CPB);
`else
    if (par_flip) $display("note: parity flip has no effect in the 8N1 build");
`endif
    rxd = stop; tick(CPB);
    rxd = 1'b1;
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    chk(name, rx_data, exp);
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         exp_cnt;
    logic       exp_full;
    int         exp_ferr;
  } vec_t;

  vec_t tv[6];
  logic [7:0] drain_exp[4];
  logic [7:0] q[$];
  int f0, o0, lat, eferr, eovr;

  initial begin
    tv[0] = '{8'h11, 1'b1, 1, 1'b0, 0};
    tv[1] = '{8'h3C, 1'b0, 1, 1'b0, 1};
    tv[2] = '{8'h55, 1'b1, 2, 1'b0, 1};
    tv[3] = '{8'h00, 1'b1, 3, 1'b0, 1};
    tv[4] = '{8'hFF, 1'b0, 3, 1'b0, 2};
    tv[5] = '{8'h80, 1'b1, 4, 1'b1, 2};
    drain_exp = '{8'h11, 8'h55, 8'h00, 8'h80};

    // reset state
    tick(3);
    chk("rst_empty", rx_empty, 1); chk("rst_full", rx_full, 0);
    chk("rst_count", rx_count, 0); chk("rst_data", rx_data, 0);
    rst = 1'b1; tick(4);

    // single byte and pin-to-empty latency
    lat = 0;
    fork
      send(8'hA5, 1'b1, 1'b0);
      begin
        while (rx_empty && lat < LAT + 40) begin tick(1); lat++; end
      end
    join
    chk("latency_in_window", (lat >= LAT - 1 && lat <= LAT + 1), 1);
    chk("single_count", rx_count, 1);
    pop_check("single_data", 8'hA5);
    chk("single_empty", rx_empty, 1); chk("single_count0", rx_count, 0);

    // vector table
    f0 = n_ferr;
    foreach (tv[i]) begin
      send(tv[i].d, tv[i].stop, 1'b0);
      tick(2 * CPB);
      chk($sformatf("tv%0d_count", i), rx_count, tv[i].exp_cnt);
      chk($sformatf("tv%0d_full", i), rx_full, tv[i].exp_full);
      chk($sformatf("tv%0d_ferr", i), n_ferr - f0, tv[i].exp_ferr);
    end
    foreach (drain_exp[i]) pop_check($sformatf("tv_drain%0d", i), drain_exp[i]);
    chk("tv_empty", rx_empty, 1);

    // framing error with the line held low, then a good byte
    f0 = n_ferr;
    send(8'h3C, 1'b0, 1'b0);
    rxd = 1'b0; tick(40); rxd = 1'b1; tick(CPB);
    send(8'h55, 1'b1, 1'b0); tick(4);
    chk("ferr_once", n_ferr - f0, 1);
    chk("ferr_count", rx_count, 1);
    pop_check("ferr_data", 8'h55);

    // glitch rejection
    f0 = n_ferr; o0 = n_ovr;
    rxd = 1'b0; tick(3); rxd = 1'b1; tick(400);
    chk("glitch_count", rx_count, 0);
    chk("glitch_flags", (n_ferr - f0) + (n_ovr - o0), 0);

    // overrun, no reads
    o0 = n_ovr;
    for (int b = 1; b <= 5; b++) begin
      send(8'(b), 1'b1, 1'b0);
      if (b == 4) chk("ovr_full_after4", rx_full, 1);
    end
    tick(4);
    chk("ovr_once", n_ovr - o0, 1);
    for (int b = 1; b <= 4; b++) pop_check($sformatf("ovr_read%0d", b), 8'(b));
    chk("ovr_empty", rx_empty, 1);

    // overrun avoided by a pop coincident with the 5th push
    o0 = n_ovr;
    for (int b = 1; b <= 4; b++) send(8'(b), 1'b1, 1'b0);
    fork
      send(8'h05, 1'b1, 1'b0);
      begin
        repeat (LAT) @(posedge clk);
        #1 rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
      end
    join
    tick(4);
    chk("coinc_no_ovr", n_ovr - o0, 0);
    chk("coinc_count", rx_count, 4);
    for (int b = 2; b <= 5; b++) pop_check($sformatf("coinc_read%0d", b), 8'(b));

    // reset mid-frame
    send(8'h11, 1'b1, 1'b0); tick(2);
    rxd = 1'b0; tick(CPB);
    rxd = 1'b1; tick(4 * CPB + CPB / 2);
    rst = 1'b0; #2;
    chk("mid_rst_empty", rx_empty, 1); chk("mid_rst_full", rx_full, 0);
    chk("mid_rst_count", rx_count, 0); chk("mid_rst_data", rx_data, 0);
    chk("mid_rst_flags", {frame_err, overrun}, 0);
    tick(3); rst = 1'b1; tick(5 * CPB);
    send(8'h81, 1'b1, 1'b0); tick(4);
    chk("mid_rst_cnt1", rx_count, 1);
    pop_check("mid_rst_data81", 8'h81);
    chk("mid_rst_empty2", rx_empty, 1);

`ifdef UART_RX_PARITY_EN
    f0 = n_perr;
    send(8'h07, 1'b1, 1'b0); tick(4);
    chk("par_good_no_pulse", n_perr - f0, 0);
    send(8'h07, 1'b1, 1'b1); tick(4);
    chk("par_bad_pulse", n_perr - f0, 1);
    chk("par_both_stored", rx_count, 2);
    pop_check("par_d0", 8'h07); pop_check("par_d1", 8'h07);
`endif

    // randomized frames against a queue model
    f0 = n_ferr; o0 = n_ovr; eferr = 0; eovr = 0;
    for (int it = 0; it < 24; it++) begin
      logic [7:0] d;
      logic stop;
      int nr;
      d = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      send(d, stop, 1'b0);
      tick(CPB + 4);
      if (!stop) eferr++;
      else if (q.size() < DEPTH) q.push_back(d);
      else eovr++;
      chk($sformatf("rnd%0d_count", it), rx_count, q.size());
      nr = $urandom_range(0, 3);
      for (int k = 0; k < nr; k++) begin
        if (q.size() > 0) pop_check($sformatf("rnd%0d_pop", it), q.pop_front());
        else begin
          rd_en = 1'b1; tick(1); rd_en = 1'b0;
          chk($sformatf("rnd%0d_empty_pop", it), {rx_empty, rx_count}, 4'b1000);
        end
      end
    end
    chk("rnd_ferr_total", n_ferr - f0, eferr);
    chk("rnd_ovr_total", n_ovr - o0, eovr);
    while (q.size() > 0) pop_check("rnd_drain", q.pop_front());
    chk("rnd_final_empty", rx_empty, 1);
    chk("no_coincident_flags", both_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
